// File: rtl/NVM_pkg.sv
// Shared GC definitions: page-move FSM state encoding and the default clean-block low-water mark.
package NVM_pkg;

  typedef enum logic [1:0] {
    MV_IDLE  = 2'd0,
    MV_READ  = 2'd1,
    MV_WRITE = 2'd2,
    MV_DONE  = 2'd3
  } move_state_t;

  localparam int GC_THRESH_DEF = 2;

endpackage

// File: rtl/clean_blk_fifo.sv
// Clean-block FIFO (capacity 2^PTR_W-1): head is readable combinationally, push/pop commit at the clock edge.
// Pushes into a full FIFO and pops from an empty one are dropped; GC_RECOVER_EN adds a read-pointer restore port.
module clean_blk_fifo #(
  parameter int PTR_W = 4,
  parameter int DAT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [DAT_W-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [DAT_W-1:0] o_head_dat,
  output logic [PTR_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
`ifdef GC_RECOVER_EN
  ,
  output logic [PTR_W-1:0] o_rd_ptr,
  input  logic             i_restore,
  input  logic [PTR_W-1:0] i_restore_ptr
`endif
);

  localparam int DEPTH = 1 << PTR_W;
  localparam logic [PTR_W-1:0] CAP = PTR_W'(DEPTH - 1);

  logic [DAT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             w_push_acc;
  logic             w_pop_acc;

  // One slot always stays free, so the pointer distance alone encodes occupancy.
  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_full     = (o_count == CAP);
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_push_acc = i_push & ~o_full;
  assign w_pop_acc  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_acc) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
`ifdef GC_RECOVER_EN
      if (i_restore) begin
        r_rd_ptr <= i_restore_ptr;
      end else if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
`else
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
`endif
    end
  end

`ifdef GC_RECOVER_EN
  assign o_rd_ptr = r_rd_ptr;
`endif

endmodule

// File: rtl/gc_responder.sv
// GC responder: clean-block FIFO with init fill and same-cycle alloc grant, plus a READ/WRITE page-move FSM.
// Move commands hold until mem_ready; GC_RECOVER_EN restores the FIFO read pointer when a move is interrupted.
module gc_responder
  import NVM_pkg::*;
#(
  parameter int FIFO_SIZE_BIT_NUM = 4,
  parameter int BLK_ADDR_W        = 8,
  parameter int PAGES_PER_BLK     = 16,
  parameter int GC_THRESH         = GC_THRESH_DEF
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             initial_fifo,
  input  logic                             fifo_write_en,
  input  logic                             request_blk_clean,
  input  logic                             move_flag,
  input  logic                             gc_interrupt,
  input  logic [BLK_ADDR_W-1:0]            erase_blk,
  input  logic                             alloc_req,
  input  logic                             mem_ready,
  output logic                             gc_ini,
  output logic                             gc_start,
  output logic                             move_done_flag,
  output logic                             fifo_recover_en,
  output logic                             ini_full,
  output logic [FIFO_SIZE_BIT_NUM-1:0]     clean_num,
  output logic                             alloc_valid,
  output logic [BLK_ADDR_W-1:0]            alloc_blk,
  output logic                             mem_rd,
  output logic                             mem_wr,
  output logic [$clog2(PAGES_PER_BLK)-1:0] mem_page
);

  localparam int PAGE_W = $clog2(PAGES_PER_BLK);
  localparam logic [FIFO_SIZE_BIT_NUM-1:0] CAP_M1 = FIFO_SIZE_BIT_NUM'((1 << FIFO_SIZE_BIT_NUM) - 2);
  localparam logic [FIFO_SIZE_BIT_NUM-1:0] THRESH = FIFO_SIZE_BIT_NUM'(GC_THRESH);
  localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(PAGES_PER_BLK - 1);

  move_state_t                  r_state;
  logic [PAGE_W-1:0]            r_page;
  logic                         r_mem_rd;
  logic                         r_mem_wr;
  logic                         r_done;
  logic                         r_init_d;
  logic                         r_ini_full;
  logic                         r_gc_ini;
  logic [BLK_ADDR_W-1:0]        r_init_addr;
  logic [FIFO_SIZE_BIT_NUM-1:0] w_count;
  logic [BLK_ADDR_W-1:0]        w_head;
  logic [BLK_ADDR_W-1:0]        w_push_dat;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_init_push;
  logic                         w_erase_push;
  logic                         w_push;
  logic                         w_push_acc;
  logic                         w_pop;
  logic                         w_init_rise;
  logic                         w_fill_done;
  logic                         w_abort;
`ifdef GC_RECOVER_EN
  logic [FIFO_SIZE_BIT_NUM-1:0] w_rd_ptr;
  logic [FIFO_SIZE_BIT_NUM-1:0] r_ckpt;
  logic                         r_recover;
`endif

  assign w_init_rise  = initial_fifo & ~r_init_d;
  assign w_init_push  = initial_fifo & ~w_full;
  assign w_erase_push = fifo_write_en & request_blk_clean & ~initial_fifo;
  assign w_push       = w_init_push | w_erase_push;
  assign w_push_acc   = w_push & ~w_full;
  assign w_push_dat   = initial_fifo ? r_init_addr : erase_blk;
  assign w_abort      = gc_interrupt & ((r_state == MV_READ) | (r_state == MV_WRITE));
`ifdef GC_RECOVER_EN
  // The restore owns the read pointer on an abort cycle, so no grant is issued then.
  assign w_pop        = alloc_req & ~w_empty & ~w_abort;
`else
  assign w_pop        = alloc_req & ~w_empty;
`endif
  // Initialization completes when the FIFO is full after this cycle's push/pop.
  assign w_fill_done  = initial_fifo & ((w_full & ~w_pop) | (w_push_acc & ~w_pop & (w_count == CAP_M1)));

  clean_blk_fifo #(
    .PTR_W (FIFO_SIZE_BIT_NUM),
    .DAT_W (BLK_ADDR_W)
  ) u_fifo (
    .i_clk         (CLK),
    .i_rst         (RST),
    .i_push        (w_push),
    .i_push_dat    (w_push_dat),
    .i_pop         (w_pop),
    .o_head_dat    (w_head),
    .o_count       (w_count),
    .o_full        (w_full),
    .o_empty       (w_empty)
`ifdef GC_RECOVER_EN
    ,
    .o_rd_ptr      (w_rd_ptr),
    .i_restore     (w_abort),
    .i_restore_ptr (r_ckpt)
`endif
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_init_d    <= 1'b0;
      r_init_addr <= '0;
      r_ini_full  <= 1'b0;
      r_gc_ini    <= 1'b0;
    end else begin
      r_init_d <= initial_fifo;
      if (!initial_fifo) begin
        r_init_addr <= '0;
      end else if (w_init_push) begin
        r_init_addr <= r_init_addr + BLK_ADDR_W'(1);
      end
      r_gc_ini <= 1'b0;
      if (w_init_rise) begin
        r_ini_full <= 1'b0;
      end else if (w_fill_done && !r_ini_full) begin
        r_ini_full <= 1'b1;
        r_gc_ini   <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= MV_IDLE;
      r_page   <= '0;
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MV_IDLE: begin
          if (move_flag) begin
            r_state  <= MV_READ;
            r_mem_rd <= 1'b1;
          end
        end
        MV_READ: begin
          if (gc_interrupt) begin
            r_state  <= MV_IDLE;
            r_page   <= '0;
            r_mem_rd <= 1'b0;
          end else if (mem_ready) begin
            r_state  <= MV_WRITE;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b1;
          end
        end
        MV_WRITE: begin
          if (gc_interrupt) begin
            r_state  <= MV_IDLE;
            r_page   <= '0;
            r_mem_wr <= 1'b0;
          end else if (mem_ready) begin
            r_mem_wr <= 1'b0;
            if (r_page == LAST_PAGE) begin
              r_state <= MV_DONE;
              r_page  <= '0;
              r_done  <= 1'b1;
            end else begin
              r_state  <= MV_READ;
              r_page   <= r_page + PAGE_W'(1);
              r_mem_rd <= 1'b1;
            end
          end
        end
        MV_DONE: begin
          r_state <= MV_IDLE;
        end
        default: begin
          r_state <= MV_IDLE;
        end
      endcase
    end
  end

`ifdef GC_RECOVER_EN
  // Checkpoint the read pointer as it will stand after any grant in the launch cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ckpt    <= '0;
      r_recover <= 1'b0;
    end else begin
      r_recover <= w_abort;
      if ((r_state == MV_IDLE) && move_flag) begin
        r_ckpt <= w_rd_ptr + FIFO_SIZE_BIT_NUM'(w_pop);
      end
    end
  end
  assign fifo_recover_en = r_recover;
`else
  assign fifo_recover_en = 1'b0;
`endif

  assign clean_num      = w_count;
  assign alloc_valid    = w_pop;
  assign alloc_blk      = w_pop ? w_head : '0;
  assign ini_full       = r_ini_full;
  assign gc_ini         = r_gc_ini;
  assign gc_start       = r_ini_full & (w_count <= THRESH) & (r_state == MV_IDLE);
  assign mem_rd         = r_mem_rd;
  assign mem_wr         = r_mem_wr;
  assign mem_page       = r_page;
  assign move_done_flag = r_done;

endmodule
